// File: rtl/rev_capture_sched_if.sv
// Requester/capture bus between the requesters and rev_capture_sched.
// The slave modport is the scheduler and the master modport is the requester side.
interface rev_capture_sched_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       i_req;
    logic [N_REQ*WIDTH-1:0] i_data;
    logic [N_REQ-1:0]       o_gnt;
    logic                   o_en;
    logic [WIDTH-1:0]       o_a;
    logic [WIDTH-1:0]       o_rev;
    logic                   o_rev_valid;
    logic [ID_W-1:0]        o_rev_id;
    logic                   o_busy;

    modport master (
        output i_req, i_data,
        input  o_gnt, o_en, o_a, o_rev, o_rev_valid, o_rev_id, o_busy
    );

    modport slave (
        input  i_req, i_data,
        output o_gnt, o_en, o_a, o_rev, o_rev_valid, o_rev_id, o_busy
    );
endinterface

// File: rtl/rev_capture_sched.sv
// Shares one capture register between N_REQ requesters and returns the bit-reversed word.
// Define REV_CAPTURE_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module rev_capture_sched #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic               i_clk,
    input  logic               i_arst_n,
    rev_capture_sched_if.slave bus
);
    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        CAPTURE     = 2'd1,
        SETTLE_WAIT = 2'd2,
        DONE        = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             en_q, en_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] rev_q, rev_d;
    logic             rev_valid_q, rev_valid_d;
    logic [ID_W-1:0]  rev_id_q, rev_id_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
`ifndef REV_CAPTURE_SCHED_FIXED_PRIO_EN
    logic [ID_W-1:0]  ptr_q, ptr_d;
`endif

    logic             win_vld;
    logic [ID_W-1:0]  win_idx;
    logic [ID_W-1:0]  scan_idx;
    logic [WIDTH-1:0] slice [N_REQ];
    logic [WIDTH-1:0] rev_word;

    for (genvar k = 0; k < N_REQ; k++) begin : g_slice
        assign slice[k] = bus.i_data[k*WIDTH +: WIDTH];
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_rev
        assign rev_word[b] = a_q[WIDTH-1-b];
    end

    // Winner: first requesting index at or after the scan start, wrapping.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
`ifdef REV_CAPTURE_SCHED_FIXED_PRIO_EN
            scan_idx = ID_W'(i);
`else
            scan_idx = ID_W'((32'(ptr_q) + i) % N_REQ);
`endif
            if (!win_vld && bus.i_req[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        en_d        = 1'b0;
        a_d         = a_q;
        rev_d       = rev_q;
        rev_valid_d = 1'b0;
        rev_id_d    = rev_id_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
`ifndef REV_CAPTURE_SCHED_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gnt_d   = N_REQ'(1) << win_idx;
                    en_d    = 1'b1;
                    a_d     = slice[win_idx];
                    id_d    = win_idx;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                cnt_d   = CNT_W'(SETTLE - 1);
                state_d = SETTLE_WAIT;
            end
            SETTLE_WAIT: begin
                if (cnt_q == '0) begin
                    rev_d       = rev_word;
                    rev_valid_d = 1'b1;
                    rev_id_d    = id_q;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
`ifndef REV_CAPTURE_SCHED_FIXED_PRIO_EN
                ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            en_q        <= 1'b0;
            a_q         <= '0;
            rev_q       <= '0;
            rev_valid_q <= 1'b0;
            rev_id_q    <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
`ifndef REV_CAPTURE_SCHED_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            en_q        <= en_d;
            a_q         <= a_d;
            rev_q       <= rev_d;
            rev_valid_q <= rev_valid_d;
            rev_id_q    <= rev_id_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
`ifndef REV_CAPTURE_SCHED_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign bus.o_gnt       = gnt_q;
    assign bus.o_en        = en_q;
    assign bus.o_a         = a_q;
    assign bus.o_rev       = rev_q;
    assign bus.o_rev_valid = rev_valid_q;
    assign bus.o_rev_id    = rev_id_q;
    assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_rev_capture_sched.sv
// Directed bench for rev_capture_sched: reset, single grant, mid-flight reset,
// round-robin order, wrap/skip, settle stability and a two-requester contention.
module tb_rev_capture_sched;
    localparam int unsigned N_REQ  = 4;
    localparam int unsigned WIDTH  = 4;
    localparam int unsigned SETTLE = 2;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   gi      = 0;

    rev_capture_sched_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

    rev_capture_sched #(.N_REQ(N_REQ), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .i_clk    (clk),
        .i_arst_n (rst_n),
        .bus      (bus)
    );

    // Requester slices for i_data = 16'hD136 and their hand-reversed values.
    logic [3:0] sl [4] = '{4'b0110, 4'b0011, 4'b0001, 4'b1101};
    logic [3:0] rv [4] = '{4'b0110, 4'b1100, 4'b1000, 4'b1011};

    // Expected winner of each grant in order of occurrence.
`ifdef REV_CAPTURE_SCHED_FIXED_PRIO_EN
    int exp_seq [13] = '{1, 2, 0, 0, 0, 0, 0, 2, 0, 0, 1, 1, 1};
`else
    int exp_seq [13] = '{1, 2, 0, 1, 2, 3, 0, 2, 0, 2, 1, 3, 1};
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_gnt"},   16'(bus.o_gnt),       16'h0);
        chk({tag, "_en"},    16'(bus.o_en),        16'h0);
        chk({tag, "_a"},     16'(bus.o_a),         16'h0);
        chk({tag, "_rev"},   16'(bus.o_rev),       16'h0);
        chk({tag, "_valid"}, 16'(bus.o_rev_valid), 16'h0);
        chk({tag, "_id"},    16'(bus.o_rev_id),    16'h0);
        chk({tag, "_busy"},  16'(bus.o_busy),      16'h0);
    endtask

    // One complete transaction from the IDLE decision edge back to IDLE.
    task automatic run_grant(input string tag, input int idx, input logic [3:0] ea,
                             input logic [3:0] er, input bit scramble);
        logic [N_REQ-1:0]       eg;
        logic [N_REQ*WIDTH-1:0] saved;
        eg       = '0;
        eg[idx]  = 1'b1;
        saved    = bus.i_data;
        tick();
        chk({tag, "_gnt"},  16'(bus.o_gnt),  16'(eg));
        chk({tag, "_en1"},  16'(bus.o_en),   16'h1);
        chk({tag, "_a1"},   16'(bus.o_a),    16'(ea));
        chk({tag, "_busy"}, 16'(bus.o_busy), 16'h1);
        if (scramble) bus.i_data = 16'($urandom);
        tick();
        chk({tag, "_en0"},  16'(bus.o_en),  16'h0);
        chk({tag, "_gnt0"}, 16'(bus.o_gnt), 16'h0);
        chk({tag, "_a2"},   16'(bus.o_a),   16'(ea));
        if (scramble) bus.i_data = 16'($urandom);
        tick();
        chk({tag, "_a3"},     16'(bus.o_a),         16'(ea));
        chk({tag, "_en_sw"},  16'(bus.o_en),        16'h0);
        chk({tag, "_early"},  16'(bus.o_rev_valid), 16'h0);
        bus.i_data = saved;
        tick();
        chk({tag, "_valid"}, 16'(bus.o_rev_valid), 16'h1);
        chk({tag, "_rev"},   16'(bus.o_rev),       16'(er));
        chk({tag, "_id"},    16'(bus.o_rev_id),    16'(idx));
        tick();
        chk({tag, "_vdrop"}, 16'(bus.o_rev_valid), 16'h0);
        chk({tag, "_hold"},  16'(bus.o_rev),       16'(er));
        chk({tag, "_idle"},  16'(bus.o_busy),      16'h0);
    endtask

    initial begin
        rst_n      = 1'b1;
        bus.i_req  = '0;
        bus.i_data = '0;
        #3 rst_n = 1'b0;
        #1 all_zero("rst");
        tick();
        tick();
        all_zero("rst_hold");
        rst_n = 1'b1;
        tick();
        all_zero("idle_noreq");

        // Lone request on requester 1, slice 0001 reverses to 1000.
        bus.i_data = 16'h0010;
        bus.i_req  = 4'b0010;
        run_grant("single", exp_seq[gi], 4'b0001, 4'b1000, 1'b0);
        gi++;
        bus.i_req = '0;

        // Reset while in SETTLE_WAIT discards the capture.
        bus.i_data = 16'hD136;
        bus.i_req  = 4'b0100;
        tick();
        chk("mid_gnt", 16'(bus.o_gnt), 16'(4'b0001 << exp_seq[gi]));
        chk("mid_a",   16'(bus.o_a),   16'(sl[exp_seq[gi]]));
        gi++;
        bus.i_req = '0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1 all_zero("mid_rst");
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("mid_novalid", 16'(bus.o_rev_valid), 16'h0);
            chk("mid_nobusy",  16'(bus.o_busy),      16'h0);
        end

        // All four requesting: five consecutive grants, five cycles apart.
        bus.i_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            run_grant("rr", exp_seq[gi], sl[exp_seq[gi]], rv[exp_seq[gi]], 1'b0);
            gi++;
        end

        // Move the pointer to 3, then 0101 must wrap to 0 and skip to 2.
        bus.i_req = 4'b0100;
        run_grant("prep", exp_seq[gi], sl[exp_seq[gi]], rv[exp_seq[gi]], 1'b0);
        gi++;
        bus.i_req = 4'b0101;
        for (int g = 0; g < 2; g++) begin
            run_grant("wrap", exp_seq[gi], sl[exp_seq[gi]], rv[exp_seq[gi]], 1'b0);
            gi++;
        end

        // Data toggles while settling must not disturb the latched word.
        bus.i_req = 4'b0010;
        run_grant("stab", exp_seq[gi], sl[exp_seq[gi]], rv[exp_seq[gi]], 1'b1);
        gi++;

        bus.i_req = 4'b1010;
        for (int g = 0; g < 2; g++) begin
            run_grant("pair", exp_seq[gi], sl[exp_seq[gi]], rv[exp_seq[gi]], 1'b0);
            gi++;
        end
        bus.i_req = '0;
        tick();
        chk("end_idle", 16'(bus.o_busy), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
